// File: rtl/mdu_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus shift-add multiply and
// restoring divide, behind a valid/ready request and result handshake.
module mdu_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_f,
    output logic             zf,
    output logic             cf,
    output logic             of,
    output logic             sf
);

    // state | meaning
    // IDLE  | ready for a request
    // CALC  | one multiply/divide step per cycle, WIDTH cycles
    // DONE  | result and flags held until out_ready
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic               zf_q, zf_d, cf_q, cf_d, of_q, of_d, sf_q, sf_d;

    logic [WIDTH:0]     sum_ab, dif_ab;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   sc_f;
    logic               sc_cf, sc_of;
    logic               in_multi, in_div, op_div;
    logic [WIDTH:0]     mul_sum, div_hi, div_diff;
    logic [WIDTH-2:0]   div_lo;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   mc_f;

    assign in_multi = (alu_op == 4'b1001) || (alu_op == 4'b1010) ||
                      (alu_op == 4'b1011) || (alu_op == 4'b1100);
    assign in_div   = (alu_op == 4'b1011) || (alu_op == 4'b1100);
    assign op_div   = (op_q == 4'b1011) || (op_q == 4'b1100);

    assign sum_ab = {1'b0, alu_a} + {1'b0, alu_b};
    assign dif_ab = {1'b0, alu_a} - {1'b0, alu_b};
    assign sh     = alu_b[SHW-1:0];

    always_comb begin
        sc_f  = '0;
        sc_cf = 1'b0;
        sc_of = 1'b0;
        case (alu_op)
            4'b0000: begin
                sc_f  = sum_ab[WIDTH-1:0];
                sc_cf = sum_ab[WIDTH];
                sc_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                        (sum_ab[WIDTH-1] != alu_a[WIDTH-1]);
            end
            4'b0001: sc_f = alu_a << sh;
            4'b0010: sc_f = WIDTH'($signed(alu_a) < $signed(alu_b));
            4'b0011: sc_f = WIDTH'(alu_a < alu_b);
            4'b0100: sc_f = alu_a ^ alu_b;
            4'b0101: sc_f = alu_a >> sh;
            4'b0110: sc_f = alu_a | alu_b;
            4'b0111: sc_f = alu_a & alu_b;
            4'b1000: begin
                sc_f  = dif_ab[WIDTH-1:0];
                sc_cf = dif_ab[WIDTH];
                sc_of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                        (dif_ab[WIDTH-1] != alu_a[WIDTH-1]);
            end
            4'b1101: sc_f = WIDTH'($signed(alu_a) >>> sh);
            default: sc_f = '0;
        endcase
    end

    // acc holds {hi, lo} for multiply and {remainder, quotient} for divide
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, a_q} : '0);
    assign div_hi   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_lo   = acc_q[WIDTH-2:0];
    assign div_diff = div_hi - {1'b0, b_q};

    always_comb begin
        step_acc = acc_q;
        if (op_div) begin
            if (!div_diff[WIDTH])
                step_acc = {div_diff[WIDTH-1:0], div_lo, 1'b1};
            else
                step_acc = {div_hi[WIDTH-1:0], div_lo, 1'b0};
        end else begin
            step_acc = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        case (op_q)
            4'b1010, 4'b1100: mc_f = step_acc[2*WIDTH-1:WIDTH];
            default:          mc_f = step_acc[WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        zf_d    = zf_q;
        cf_d    = cf_q;
        of_d    = of_q;
        sf_d    = sf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = alu_op;
                    a_d  = alu_a;
                    b_d  = alu_b;
                    if (in_multi) begin
                        state_d = CALC;
                        cnt_d   = SHW'(WIDTH - 1);
                        acc_d   = in_div ? {{WIDTH{1'b0}}, alu_a}
                                         : {{WIDTH{1'b0}}, alu_b};
                    end else begin
                        state_d = DONE;
                        f_d     = sc_f;
                        zf_d    = (sc_f == '0);
                        sf_d    = sc_f[WIDTH-1];
                        cf_d    = sc_cf;
                        of_d    = sc_of;
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    f_d     = mc_f;
                    zf_d    = (mc_f == '0);
                    sf_d    = mc_f[WIDTH-1];
                    cf_d    = 1'b0;
                    of_d    = 1'b0;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            f_q     <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            sf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            sf_q    <= sf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign alu_f     = f_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign of        = of_q;
    assign sf        = sf_q;

endmodule

// File: tb/tb_mdu_alu.sv
// Directed bench for mdu_alu at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_mdu_alu;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  alu_op;
    logic [31:0] a32, b32, f32;
    logic        zf, cf, of, sf;

    logic        v8, r8, ov8, or8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, f8;
    logic        zf8, cf8, of8, sf8;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    logic [31:0] held;

    always #5 clk = ~clk;

    mdu_alu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .alu_a(a32), .alu_b(b32),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_f(f32), .zf(zf), .cf(cf), .of(of), .sf(sf)
    );

    mdu_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(r8),
        .alu_op(op8), .alu_a(a8), .alu_b(b8),
        .out_valid(ov8), .out_ready(or8),
        .alu_f(f8), .zf(zf8), .cf(cf8), .of(of8), .sf(sf8)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request on the 32-bit instance and count cycles to out_valid.
    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int l);
        @(negedge clk);
        in_valid = 1'b1; alu_op = op; a32 = a; b32 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_op = 4'b0000; a32 = ~a; b32 = ~b;
        l = 1;
        while (out_valid !== 1'b1 && l < 100) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic pop32();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1("in_ready_after_pop", in_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; a32 = '0; b32 = '0;
        v8 = 1'b0; or8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_f", f32, 32'h0);
        chk1("rst_flags", zf | cf | of | sf, 1'b0);
        rst_n = 1'b1;

        run32(4'b0000, 32'h7FFF_FFFF, 32'h1, lat);
        chki("add_ovf_lat", lat, 1);
        chk32("add_ovf_f", f32, 32'h8000_0000);
        chk1("add_ovf_of", of, 1'b1);
        chk1("add_ovf_sf", sf, 1'b1);
        chk1("add_ovf_cf", cf, 1'b0);
        chk1("add_ovf_zf", zf, 1'b0);
        pop32();

        run32(4'b1000, 32'h0, 32'h1, lat);
        chki("sub_lat", lat, 1);
        chk32("sub_f", f32, 32'hFFFF_FFFF);
        chk1("sub_cf", cf, 1'b1);
        chk1("sub_of", of, 1'b0);
        held = f32;
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'b0110; a32 = 32'h1234_5678; b32 = 32'h1;
        repeat (5) begin
            @(posedge clk); #1;
            chk32("sub_hold_f", f32, held);
            chk1("sub_hold_in_ready", in_ready, 1'b0);
            chk1("sub_hold_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        pop32();

        run32(4'b1001, 32'h0001_0000, 32'h0001_0000, lat);
        chki("mul_lat", lat, 33);
        chk32("mul_f", f32, 32'h0);
        chk1("mul_zf", zf, 1'b1);
        pop32();
        run32(4'b1010, 32'h0001_0000, 32'h0001_0000, lat);
        chki("mulhu_lat", lat, 33);
        chk32("mulhu_f", f32, 32'h1);
        chk1("mulhu_zf", zf, 1'b0);
        pop32();
        run32(4'b1001, 32'h0000_1234, 32'h0000_0100, lat);
        chk32("mul_small_f", f32, 32'h0012_3400);
        pop32();

        run32(4'b1011, 32'd100, 32'd7, lat);
        chki("divu_lat", lat, 33);
        chk32("divu_f", f32, 32'd14);
        pop32();
        run32(4'b1100, 32'd100, 32'd7, lat);
        chki("remu_lat", lat, 33);
        chk32("remu_f", f32, 32'd2);
        pop32();
        run32(4'b1011, 32'd100, 32'd0, lat);
        chki("divu0_lat", lat, 33);
        chk32("divu0_f", f32, 32'hFFFF_FFFF);
        chk1("divu0_sf", sf, 1'b1);
        pop32();
        run32(4'b1100, 32'd100, 32'd0, lat);
        chki("remu0_lat", lat, 33);
        chk32("remu0_f", f32, 32'd100);
        pop32();

        run32(4'b0000, 32'hFFFF_FFFF, 32'h1, lat);
        chk32("add_carry_f", f32, 32'h0);
        chk1("add_carry_cf", cf, 1'b1);
        chk1("add_carry_zf", zf, 1'b1);
        chk1("add_carry_of", of, 1'b0);
        pop32();
        run32(4'b1110, 32'hDEAD_BEEF, 32'h5, lat);
        chk32("op1110_f", f32, 32'h0);
        chk1("op1110_zf", zf, 1'b1);
        pop32();
        run32(4'b0011, 32'hFFFF_FFFF, 32'h1, lat);
        chk32("sltu_f", f32, 32'h0);
        pop32();
        run32(4'b0010, 32'hFFFF_FFFF, 32'h1, lat);
        chk32("slt_f", f32, 32'h1);
        pop32();
        run32(4'b0001, 32'h0000_0003, 32'h0000_0024, lat);
        chk32("sll_f", f32, 32'h0000_0030);
        pop32();
        run32(4'b0101, 32'h8000_0000, 32'h0000_001F, lat);
        chk32("srl_f", f32, 32'h0000_0001);
        pop32();
        run32(4'b1101, 32'h8000_0000, 32'h0000_003F, lat);
        chk32("sra_f", f32, 32'hFFFF_FFFF);
        chk1("sra_sf", sf, 1'b1);
        pop32();

        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'b1011; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk32("midrst_f", f32, 32'h0);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_sf", sf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; alu_op = 4'b0000; a32 = 32'd2; b32 = 32'd3;
        chk1("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("postrst_out_valid", out_valid, 1'b1);
        chk32("postrst_f", f32, 32'd5);
        pop32();

        @(negedge clk);
        v8 = 1'b1; op8 = 4'b0000; a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk); #1;
        v8 = 1'b0; a8 = 8'h00;
        chk1("w8_out_valid", ov8, 1'b1);
        chk32("w8_f", {24'h0, f8}, 32'h0000_0080);
        chk1("w8_of", of8, 1'b1);
        chk1("w8_sf", sf8, 1'b1);
        chk1("w8_cf", cf8, 1'b0);
        chk1("w8_zf", zf8, 1'b0);
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk1("w8_in_ready", r8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_alu.md
MDU_ALU -- requirements
Module: mdu_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), the shift-amount width; it is derived and never overridden.
REQ-003 The block SHALL run on one clock and use a synchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port alu_op, input, 4 bits: operation code.
REQ-009 The block SHALL have port alu_a, input, WIDTH bits: operand A.
REQ-010 The block SHALL have port alu_b, input, WIDTH bits: operand B.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port alu_f, output, WIDTH bits: registered result.
REQ-014 The block SHALL have ports zf, cf, of, sf, output, 1 bit each: registered zero, carry/borrow, signed-overflow and sign flags.

Function
REQ-015 The block SHALL implement single-cycle-class opcodes: 0000 add; 0001 sll; 0010 slt (signed); 0011 sltu; 0100 xor; 0101 srl; 0110 or; 0111 and; 1000 sub; 1101 sra.
REQ-016 The block SHALL implement multi-cycle opcodes: 1001 mul (low WIDTH bits of unsigned A*B); 1010 mulhu (high WIDTH bits); 1011 divu (quotient); 1100 remu (remainder).
REQ-017 Opcodes 1110 and 1111 SHALL be accepted as single-cycle-class operations and produce alu_f=0 with all flags computed per REQ-024..REQ-026.
REQ-018 Shifts SHALL use alu_b[SHW-1:0] only, and sra SHALL replicate alu_a[WIDTH-1].
REQ-019 The FSM SHALL have states IDLE, CALC and DONE, with in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-020 On an accept (in_valid & in_ready) of a single-cycle-class operation, the FSM SHALL go IDLE->DONE, with the result visible in the cycle after the accept edge (latency 1).
REQ-021 On an accept of a multi-cycle operation, the FSM SHALL go IDLE->CALC, spend exactly WIDTH cycles in CALC (one shift-add or restoring-divide step per cycle), then go to DONE; out_valid SHALL rise after the accept edge + WIDTH + 1.
REQ-022 Operands and opcode SHALL be captured at accept; input changes afterwards SHALL have no effect.
REQ-023 In DONE, alu_f and all flags SHALL hold stable until out_valid & out_ready, after which the FSM SHALL go DONE->IDLE. No new request SHALL be accepted in the same cycle.
REQ-024 zf SHALL equal (alu_f==0), and sf SHALL equal alu_f[WIDTH-1], for every opcode.
REQ-025 cf SHALL be the carry-out of A+B for add, 1 when A<B unsigned (borrow) for sub, and 0 for all other opcodes.
REQ-026 of SHALL be the signed overflow for add ((A,B same sign) and F sign differs) and for sub ((A,B signs differ) and F sign differs from A), and 0 for all other opcodes.
REQ-027 When B=0, divu SHALL return all ones and remu SHALL return A, with the full WIDTH-cycle latency retained.
REQ-028 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.

Reset
REQ-029 When rst_n=0 at a rising edge, the block SHALL go to IDLE and clear alu_f, zf, cf, of, sf and out_valid to 0, setting in_ready to 1 from the next cycle.
REQ-030 A reset during CALC or DONE SHALL abort the operation with no result produced, and a request presented in the first cycle after reset release SHALL be accepted normally.

Verification (WIDTH=32 unless noted)
REQ-031 The bench SHALL cover: add A=0x7FFFFFFF, B=1 -> next cycle out_valid=1, F=0x80000000, of=1, sf=1, cf=0, zf=0.
REQ-032 The bench SHALL cover: sub A=0, B=1 -> F=0xFFFFFFFF, cf=1, of=0; with out_ready held 0 for 5 cycles, F stays stable and in_ready stays 0.
REQ-033 The bench SHALL cover: mul A=0x00010000, B=0x00010000 -> out_valid rises exactly 33 cycles after accept, F=0; then mulhu with the same operands -> F=1, zf=0.
REQ-034 The bench SHALL cover: divu A=100, B=7 -> F=14; remu -> F=2; divu B=0 -> F=0xFFFFFFFF; remu B=0 -> F=100, each with 33-cycle latency.
REQ-035 The bench SHALL cover: sra A=0x80000000, B=0x3F (low 5 bits = 31) -> F=0xFFFFFFFF; slt A=-1, B=1 -> F=1; sltu with the same operands -> F=0.
REQ-036 The bench SHALL cover: rst_n=0 mid-CALC of a divu, then release -> outputs 0, no out_valid pulse; an immediate add 2+3 -> F=5 with latency 1. The bench SHALL repeat REQ-031 with WIDTH=8 (0x7F+1 -> 0x80, of=1).
